regfile_dump_streamer: RTL and testbench

//  Debug reader for the CPU's 32x32 register file: on a start pulse, walks every register through
//  a dedicated read port and streams the contents as a byte frame to the UART transmit path.

---
 rtl/mips_debug_pkg.sv | 17 +
 rtl/word_byte_serializer.sv | 50 +++++
 rtl/regfile_dump_streamer.sv | 111 +++++++++++
 tb/tb_regfile_dump_streamer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_debug_pkg.sv
// rtl/mips_debug_pkg.sv - shared constants and FSM encoding for the register-file dump streamer
package mips_debug_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
    localparam int         NUM_REGS_DEF   = 32;
    localparam int         BYTES_PER_WORD = 5;
    localparam int         FRAME_BYTES    = 1 + NUM_REGS_DEF * BYTES_PER_WORD;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_LOAD = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } dump_state_t;

endpackage

// File: rtl/word_byte_serializer.sv
// rtl/word_byte_serializer.sv - emits {index, word[31:24..7:0]} as five bytes over valid/ready
module word_byte_serializer
    import mips_debug_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_index,
    input  logic [31:0]       i_word,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_last_accept
);

    logic [39:0] r_shift;
    logic [2:0]  r_cnt;
    logic        r_valid;
    logic        w_accept;
    logic        w_last;

    assign w_accept      = r_valid & i_tx_ready;
    assign w_last        = w_accept && (r_cnt == 3'(BYTES_PER_WORD - 1));
    assign o_tx_data     = r_shift[39:32];
    assign o_tx_valid    = r_valid;
    assign o_last_accept = w_last;

    // The outgoing byte is always the top of the shift register, so it only moves on an accept.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= {{(8-ADDR_W){1'b0}}, i_index, i_word};
            r_cnt   <= '0;
            r_valid <= 1'b1;
        end else if (w_accept) begin
            if (w_last) begin
                r_valid <= 1'b0;
            end else begin
                r_shift <= {r_shift[31:0], 8'h00};
                r_cnt   <= r_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/regfile_dump_streamer.sv
// rtl/regfile_dump_streamer.sv - walks the register file via a read port and streams a byte frame
module regfile_dump_streamer
    import mips_debug_pkg::*;
#(
    parameter int         NUM_REGS  = NUM_REGS_DEF,
    parameter int         ADDR_W    = 5,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_dbg_addr,
    input  logic [31:0]       i_dbg_data,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready
);

    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(NUM_REGS - 1);

    dump_state_t       r_state;
    logic [ADDR_W-1:0] r_index;
    logic [ADDR_W-1:0] r_dbg_addr;
    logic              r_busy;
    logic              r_done;
    logic              r_sync_valid;

    logic              w_load;
    logic [7:0]        w_ser_data;
    logic              w_ser_valid;
    logic              w_ser_last;

    assign w_load = (r_state == ST_LOAD);

    word_byte_serializer #(
        .ADDR_W (ADDR_W)
    ) u_serializer (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_load        (w_load),
        .i_index       (r_index),
        .i_word        (i_dbg_data),
        .o_tx_data     (w_ser_data),
        .o_tx_valid    (w_ser_valid),
        .i_tx_ready    (i_tx_ready),
        .o_last_accept (w_ser_last)
    );

    // SYNC byte and word bytes come from separate registers that are never valid together.
    assign o_tx_valid = r_sync_valid | w_ser_valid;
    assign o_tx_data  = r_sync_valid ? SYNC_BYTE : w_ser_data;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_dbg_addr = r_dbg_addr;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_index      <= '0;
            r_dbg_addr   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sync_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state      <= ST_SYNC;
                        r_busy       <= 1'b1;
                        r_index      <= '0;
                        r_dbg_addr   <= '0;
                        r_sync_valid <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (r_sync_valid && i_tx_ready) begin
                        r_sync_valid <= 1'b0;
                        r_state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_ser_last) begin
                        if (r_index == LAST_INDEX) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            // Address moves one cycle ahead of the LOAD that samples it.
                            r_index    <= r_index + 1'b1;
                            r_dbg_addr <= r_index + 1'b1;
                            r_state    <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_streamer.sv
// tb/tb_regfile_dump_streamer.sv - directed self-checking bench for regfile_dump_streamer
module tb_regfile_dump_streamer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    logic [31:0] rf [32];
    logic [31:0] exp_rf [32];
    logic        preset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    logic [7:0]  rx_q [$];
    logic [7:0]  exp_q [$];
    int          done_cnt;
    int          busy_cycles;
    int          hold_viol;
    logic        prev_stall;
    logic [7:0]  prev_data;
    int          rdy_mode;

    int          tests_run;
    int          tests_failed;

    always #5 clk = ~clk;

    regfile_dump_streamer dut (
        .i_clock    (clk),
        .i_reset    (reset),
        .i_start    (start),
        .o_busy     (busy),
        .o_done     (done),
        .o_dbg_addr (dbg_addr),
        .i_dbg_data (dbg_data),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready)
    );

    always @(posedge clk) begin
        if (preset) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h1000_0000 + i;
        end else if (wr_en) begin
            rf[wr_addr] <= wr_data;
        end
    end
    assign dbg_data = rf[dbg_addr];

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ($urandom_range(0, 9) < 3);
            default: tx_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!tx_valid || tx_data !== prev_data)) hold_viol++;
            if (tx_valid && tx_ready) rx_q.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (done) done_cnt++;
            if (busy) busy_cycles++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void build_expected();
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(8'(i));
            exp_q.push_back(exp_rf[i][31:24]);
            exp_q.push_back(exp_rf[i][23:16]);
            exp_q.push_back(exp_rf[i][15:8]);
            exp_q.push_back(exp_rf[i][7:0]);
        end
    endfunction

    function automatic int frame_errors();
        int n = 0;
        if (rx_q.size() != exp_q.size()) n++;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            if (rx_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    task automatic start_frame();
        rx_q.delete();
        done_cnt    = 0;
        busy_cycles = 0;
        hold_viol   = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; preset = 1'b1;
        tick(); tick();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %0b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %0b want 0", done); end
        tests_run++; if (dbg_addr !== 5'd0) begin tests_failed++; $display("FAIL reset_addr got %0d want 0", dbg_addr); end
        tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b want 0", tx_valid); end
        tests_run++; if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data got %h want 00", tx_data); end
        reset = 1'b0; preset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit to;
        rdy_mode = 0;
        build_expected();
        start_frame();
        wait_done(2000, to);
        tests_run++; if (to) begin tests_failed++; $display("FAIL basic_timeout got timeout want done"); end
        tests_run++; if (rx_q.size() != 161) begin tests_failed++; $display("FAIL basic_len got %0d want 161", rx_q.size()); end
        tests_run++;
        if ({rx_q[0], rx_q[1], rx_q[2], rx_q[3], rx_q[4], rx_q[5]} !== 48'hA5_00_10_00_00_00) begin
            tests_failed++;
            $display("FAIL basic_head got %h %h %h %h %h %h want a5 00 10 00 00 00",
                     rx_q[0], rx_q[1], rx_q[2], rx_q[3], rx_q[4], rx_q[5]);
        end
        tests_run++;
        if ({rx_q[156], rx_q[157], rx_q[158], rx_q[159], rx_q[160]} !== 40'h1F_10_00_00_1F) begin
            tests_failed++;
            $display("FAIL basic_tail got %h %h %h %h %h want 1f 10 00 00 1f",
                     rx_q[156], rx_q[157], rx_q[158], rx_q[159], rx_q[160]);
        end
        tests_run++; if (frame_errors() != 0) begin tests_failed++; $display("FAIL basic_frame got %0d bad bytes want 0", frame_errors()); end
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL basic_done got %0d pulses want 1", done_cnt); end
        tests_run++; if (busy_cycles != 193) begin tests_failed++; $display("FAIL basic_busy_cycles got %0d want 193", busy_cycles); end
    endtask

    task automatic test_random_ready();
        bit to;
        rdy_mode = 1;
        build_expected();
        start_frame();
        wait_done(5000, to);
        rdy_mode = 0;
        tests_run++; if (to) begin tests_failed++; $display("FAIL rand_timeout got timeout want done"); end
        tests_run++; if (frame_errors() != 0) begin tests_failed++; $display("FAIL rand_frame got %0d bad bytes want 0", frame_errors()); end
        tests_run++; if (hold_viol != 0) begin tests_failed++; $display("FAIL rand_hold got %0d violations want 0", hold_viol); end
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL rand_done got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_consistency();
        bit to;
        bit found;
        rdy_mode = 0;
        exp_rf[6] = 32'hDEAD_BEEF;
        build_expected();
        start_frame();
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (busy && !tx_valid && dbg_addr == 5'd5) begin found = 1'b1; break; end
        end
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        wr_addr = 5'd6;
        @(negedge clk);
        wr_en = 1'b0;
        wait_done(2000, to);
        tests_run++; if (!found || to) begin tests_failed++; $display("FAIL cons_progress got found=%0b timeout=%0b want 1 0", found, to); end
        tests_run++;
        if ({rx_q[26], rx_q[27], rx_q[28], rx_q[29], rx_q[30]} !== 40'h05_10_00_00_05) begin
            tests_failed++;
            $display("FAIL cons_r5 got %h %h %h %h %h want 05 10 00 00 05",
                     rx_q[26], rx_q[27], rx_q[28], rx_q[29], rx_q[30]);
        end
        tests_run++;
        if ({rx_q[31], rx_q[32], rx_q[33], rx_q[34], rx_q[35]} !== 40'h06_DE_AD_BE_EF) begin
            tests_failed++;
            $display("FAIL cons_r6 got %h %h %h %h %h want 06 de ad be ef",
                     rx_q[31], rx_q[32], rx_q[33], rx_q[34], rx_q[35]);
        end
        tests_run++; if (frame_errors() != 0) begin tests_failed++; $display("FAIL cons_frame got %0d bad bytes want 0", frame_errors()); end
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1000_0005;
        tick();
        wr_addr = 5'd6; wr_data = 32'h1000_0006;
        tick();
        wr_en = 1'b0;
        exp_rf[6] = 32'h1000_0006;
    endtask

    task automatic test_start_ignored();
        bit to;
        rdy_mode = 0;
        build_expected();
        start_frame();
        repeat (50) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin to = 1'b0; break; end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (300) tick();
        tests_run++; if (to) begin tests_failed++; $display("FAIL ign_timeout got timeout want done"); end
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL ign_done got %0d pulses want 1", done_cnt); end
        tests_run++; if (rx_q.size() != 161) begin tests_failed++; $display("FAIL ign_len got %0d want 161", rx_q.size()); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL ign_busy got %0b want 0", busy); end
        tests_run++; if (frame_errors() != 0) begin tests_failed++; $display("FAIL ign_frame got %0d bad bytes want 0", frame_errors()); end
    endtask

    task automatic test_reset_mid();
        bit to;
        rdy_mode = 0;
        build_expected();
        start_frame();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (rx_q.size() >= 40) break;
        end
        reset = 1'b1;
        tick();
        tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_valid got %0b want 0", tx_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_busy got %0b want 0", busy); end
        tests_run++; if (dbg_addr !== 5'd0) begin tests_failed++; $display("FAIL rmid_addr got %0d want 0", dbg_addr); end
        reset = 1'b0;
        repeat (5) tick();
        tests_run++; if (done_cnt != 0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_abandon got done=%0d busy=%0b want 0 0", done_cnt, busy); end
        start_frame();
        wait_done(2000, to);
        tests_run++; if (to) begin tests_failed++; $display("FAIL rmid_timeout got timeout want done"); end
        tests_run++; if (rx_q[0] !== 8'hA5) begin tests_failed++; $display("FAIL rmid_first got %h want a5", rx_q[0]); end
        tests_run++; if (frame_errors() != 0 || done_cnt != 1) begin tests_failed++; $display("FAIL rmid_frame got %0d bad bytes, %0d done want 0, 1", frame_errors(), done_cnt); end
    endtask

    task automatic test_stall_sync();
        bit to;
        rdy_mode = 2;
        build_expected();
        start_frame();
        repeat (1000) tick();
        tests_run++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin tests_failed++; $display("FAIL stall_hold got valid=%0b data=%h want 1 a5", tx_valid, tx_data); end
        tests_run++; if (rx_q.size() != 0 || busy !== 1'b1) begin tests_failed++; $display("FAIL stall_progress got %0d bytes busy=%0b want 0 1", rx_q.size(), busy); end
        rdy_mode = 0;
        wait_done(2000, to);
        tests_run++; if (to) begin tests_failed++; $display("FAIL stall_timeout got timeout want done"); end
        tests_run++; if (frame_errors() != 0 || hold_viol != 0) begin tests_failed++; $display("FAIL stall_frame got %0d bad bytes, %0d hold errors want 0 0", frame_errors(), hold_viol); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rdy_mode     = 0;
        tx_ready     = 1'b1;
        start        = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        done_cnt     = 0;
        busy_cycles  = 0;
        hold_viol    = 0;
        prev_stall   = 1'b0;
        prev_data    = '0;
        for (int i = 0; i < 32; i++) exp_rf[i] = 32'h1000_0000 + i;
        test_reset();
        test_basic();
        test_random_ready();
        test_consistency();
        test_start_ignored();
        test_reset_mid();
        test_stall_sync();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
